// File: rtl/pipe_reg_chain_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_reg_chain_if                                                          |
// | Producer/consumer handshake bundle for the flow-controlled register chain. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface pipe_reg_chain_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface
`default_nettype wire

// File: rtl/pipe_reg_chain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_reg_chain                                                             |
// | DEPTH-stage valid/ready register pipeline with bubble collapsing, flush    |
// | and a registered occupancy count.                                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_reg_chain #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  wire logic        CLK,
  input  wire logic        RST,
  pipe_reg_chain_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  logic [DEPTH-1:0] acc;
  logic             ripple;
  logic [DEPTH-1:0] up_v;
  logic [WIDTH-1:0] up_d [DEPTH];

  // A stage accepts when it is empty or its downstream neighbour takes from it;
  // the ripple walks from the output side back toward the input.
  always_comb begin
    acc    = '0;
    ripple = bus.out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc[k] = !v_q[k] || ripple;
      ripple = acc[k];
    end
  end

  always_comb begin
    up_v[0] = bus.in_valid;
    up_d[0] = bus.in_data;
    for (int k = 1; k < DEPTH; k++) begin
      up_v[k] = v_q[k-1];
      up_d[k] = d_q[k-1];
    end
  end

  always_comb begin
    v_d     = v_q;
    count_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      d_d[k] = d_q[k];
      if (bus.flush) begin
        v_d[k] = 1'b0;
      end else if (acc[k]) begin
        v_d[k] = up_v[k];
        // Bubbles leave the stale data in place.
        if (up_v[k]) begin
          d_d[k] = up_d[k];
        end
      end
      count_d = count_d + CNT_W'(v_d[k]);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v_q     <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= RESET_VAL;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

  assign bus.in_ready  = acc[0] && !bus.flush;
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out_data  = d_q[DEPTH-1];
  assign bus.count     = count_q;
endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipe_reg_chain                                                          |
// | Scoreboard bench for pipe_reg_chain (WIDTH=8, DEPTH=3).                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pipe_reg_chain;
  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   nchecks = 0;
  int   npass   = 0;
  logic [WIDTH-1:0] sb [$];

  pipe_reg_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Items in flight are lost the instant reset asserts.
  always @(posedge RST) sb.delete();

  // Scoreboard monitor: samples at the falling edge what the next rising edge does.
  always @(negedge CLK) begin
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_rdy;
    logic [WIDTH-1:0] exp_d;
    if (!RST) begin
      exp_cnt = CNT_W'(sb.size());
      exp_rdy = ((sb.size() < DEPTH) || bus.out_ready) && !bus.flush;
      nchecks++;
      if (bus.count !== exp_cnt) $display("FAIL sb_count: got %0d want %0d", bus.count, exp_cnt);
      else npass++;
      nchecks++;
      if (bus.in_ready !== exp_rdy) $display("FAIL sb_in_ready: got %b want %b", bus.in_ready, exp_rdy);
      else npass++;
      if (bus.out_valid === 1'b1) begin
        nchecks++;
        if (sb.size() == 0) begin
          $display("FAIL sb_out_data: got %h want nothing (scoreboard empty)", bus.out_data);
        end else begin
          exp_d = sb[0];
          if (bus.out_data !== exp_d) $display("FAIL sb_out_data: got %h want %h", bus.out_data, exp_d);
          else npass++;
        end
      end
      if (bus.out_valid && bus.out_ready && sb.size() > 0) void'(sb.pop_front());
      if (bus.flush) sb.delete();
      if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.out_ready = 1'b0;
    repeat (3) tick();
    nchecks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else npass++;
    nchecks++;
    if (bus.out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", bus.out_data); else npass++;
    nchecks++;
    if (bus.count !== 2'd0) $display("FAIL reset_count: got %0d want 0", bus.count); else npass++;
    bus.in_valid = 1'b0;
    RST = 1'b0;
    #1;
    nchecks++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else npass++;
  endtask

  task automatic test_streaming();
    logic             ev;
    logic [WIDTH-1:0] ed;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'd1;
    for (int i = 0; i < 7; i++) begin
      tick();
      ev = (i >= 2 && i <= 5);
      ed = WIDTH'(i - 1);
      nchecks++;
      if (bus.out_valid !== ev) $display("FAIL stream_out_valid[%0d]: got %b want %b", i, bus.out_valid, ev); else npass++;
      if (ev) begin
        nchecks++;
        if (bus.out_data !== ed) $display("FAIL stream_out_data[%0d]: got %h want %h", i, bus.out_data, ed); else npass++;
      end
      if (i == 2 || i == 3) begin
        nchecks++;
        if (bus.count !== 2'd3) $display("FAIL stream_count[%0d]: got %0d want 3", i, bus.count); else npass++;
      end
      if (i < 3) bus.in_data = WIDTH'(i + 2);
      else bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int   idx = 0;
    logic rdy;
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'd11;
    for (int i = 0; i < 5; i++) begin
      rdy = bus.in_ready;
      tick();
      if (rdy) idx++;
      bus.in_data = WIDTH'(11 + idx);
    end
    nchecks++;
    if (bus.count !== 2'd3) $display("FAIL bp_count_full: got %0d want 3", bus.count); else npass++;
    nchecks++;
    if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_full: got %b want 0", bus.in_ready); else npass++;
    nchecks++;
    if (bus.out_data !== 8'd11) $display("FAIL bp_head: got %h want 0b", bus.out_data); else npass++;
    bus.out_ready = 1'b1;
    #1;
    nchecks++;
    if (bus.in_ready !== 1'b1) $display("FAIL bp_in_ready_pop: got %b want 1", bus.in_ready); else npass++;
    tick();
    bus.in_valid = 1'b0;
    nchecks++;
    if (bus.count !== 2'd3) $display("FAIL bp_count_swap: got %0d want 3", bus.count); else npass++;
    for (int i = 0; i < 3; i++) begin
      nchecks++;
      if (bus.out_data !== WIDTH'(12 + i)) $display("FAIL bp_drain[%0d]: got %h want %h", i, bus.out_data, WIDTH'(12 + i));
      else npass++;
      tick();
    end
    nchecks++;
    if (bus.out_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", bus.out_valid); else npass++;
  endtask

  task automatic test_bubble();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'd7; tick();
    bus.in_valid = 1'b0; tick();
    bus.in_valid = 1'b1; bus.in_data = 8'd8; tick();
    bus.in_valid = 1'b0; tick(); tick();
    nchecks++;
    if (bus.count !== 2'd2) $display("FAIL bubble_count: got %0d want 2", bus.count); else npass++;
    nchecks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd7)
      $display("FAIL bubble_head: got v=%b d=%h want v=1 d=07", bus.out_valid, bus.out_data);
    else npass++;
    bus.in_valid = 1'b1; bus.in_data = 8'd9; tick();
    bus.in_data = 8'd10;
    #1;
    nchecks++;
    if (bus.in_ready !== 1'b0 || bus.count !== 2'd3)
      $display("FAIL bubble_full: got rdy=%b cnt=%0d want rdy=0 cnt=3", bus.in_ready, bus.count);
    else npass++;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nchecks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== WIDTH'(7 + i))
        $display("FAIL bubble_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, bus.out_valid, bus.out_data, WIDTH'(7 + i));
      else npass++;
      tick();
    end
    nchecks++;
    if (bus.out_valid !== 1'b0) $display("FAIL bubble_empty: got %b want 0", bus.out_valid); else npass++;
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = WIDTH'(21 + i);
      tick();
    end
    bus.out_ready = 1'b1; bus.in_data = 8'h99; bus.flush = 1'b1;
    #1;
    nchecks++;
    if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); else npass++;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    nchecks++;
    if (bus.count !== 2'd0 || bus.out_valid !== 1'b0)
      $display("FAIL flush_clear: got cnt=%0d v=%b want cnt=0 v=0", bus.count, bus.out_valid);
    else npass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      nchecks++;
      if (bus.out_valid !== 1'b0) $display("FAIL flush_no_emit[%0d]: got %b want 0", i, bus.out_valid); else npass++;
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.in_data = 8'd31; tick();
    bus.in_data = 8'd32; tick();
    bus.in_valid = 1'b0; tick();
    nchecks++;
    if (bus.count !== 2'd2) $display("FAIL arst_pre_count: got %0d want 2", bus.count); else npass++;
    #2;
    RST = 1'b1;
    #1;
    nchecks++;
    if (bus.out_valid !== 1'b0 || bus.count !== 2'd0 || bus.out_data !== 8'h00)
      $display("FAIL arst_clear: got v=%b cnt=%0d d=%h want v=0 cnt=0 d=00", bus.out_valid, bus.count, bus.out_data);
    else npass++;
    tick();
    RST = 1'b0;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = WIDTH'(41 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    nchecks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd41)
      $display("FAIL arst_resume: got v=%b d=%h want v=1 d=29", bus.out_valid, bus.out_data);
    else npass++;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = WIDTH'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 24) == 0);
      tick();
    end
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    nchecks++;
    if (sb.size() != 0 || bus.count !== 2'd0)
      $display("FAIL b2b_drain: got pending=%0d cnt=%0d want 0 and 0", sb.size(), bus.count);
    else npass++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end
endmodule
`default_nettype wire
